// File: rtl/quad_dial_decoder_if.sv
// -----------------------------------------------------------------------------
// quad_dial_decoder_if
//
// Read handshake between the dial decoder and the command dispatcher.
// The consumer holds read_enable high for as long as it wants the snapshot;
// the decoder presents the captured count on out and flags it with out_valid.
//
// Signals:
//   read_enable  consumer -> decoder  level-held read request
//   out          decoder  -> consumer signed step count captured at last read
//   out_valid    decoder  -> consumer out holds the snapshot for this request
//
// Modports:
//   master  consumer side (drives read_enable)
//   slave   decoder side  (drives out / out_valid)
// -----------------------------------------------------------------------------
interface quad_dial_decoder_if #(
  parameter int COUNT_WIDTH = 8
);

  logic                          read_enable;
  logic signed [COUNT_WIDTH-1:0] out;
  logic                          out_valid;

  modport master (
    output read_enable,
    input  out,
    input  out_valid
  );

  modport slave (
    input  read_enable,
    output out,
    output out_valid
  );

endinterface

// File: rtl/quad_dial_decoder.sv
// -----------------------------------------------------------------------------
// quad_dial_decoder
//
// Front end for the front-panel rotary frequency dial. The raw quadrature
// pins are synchronised and debounced, one signed step is decoded per detent
// (on the rising edge of the filtered ck), and steps accumulate into a
// saturating signed counter. A snapshot-and-clear read hands the count to
// the command dispatcher.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed before a pin change is accepted (>=1)
//   COUNT_WIDTH      width of the signed accumulator and of rd.out (>=2)
//
// Ports:
//   aclk    system clock, single domain
//   reset   synchronous active-high master reset
//   ck      raw dial clock pin, asynchronous, idles high
//   dt      raw dial data pin, asynchronous, idles high
//   rd      read handshake (slave side): read_enable in, out/out_valid out
//
// Read FSM:
//   state | meaning
//   IDLE  | no request outstanding; waiting for a read_enable rising edge
//   HOLD  | snapshot presented on out with out_valid=1 until read_enable drops
// -----------------------------------------------------------------------------
module quad_dial_decoder #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   ck,
  input  logic                   dt,
  quad_dial_decoder_if.slave     rd
);

  // Counter only ever needs to hold 0 .. DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic signed [COUNT_WIDTH-1:0] ACC_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
  localparam logic signed [COUNT_WIDTH-1:0] ACC_MIN = {1'b1, {(COUNT_WIDTH-1){1'b0}}};
  localparam logic signed [COUNT_WIDTH-1:0] ACC_ONE = COUNT_WIDTH'(1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Pin index 0 = ck, 1 = dt.
  logic [1:0]       pin_raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       filt;
  logic [CNT_W-1:0] db_cnt [2];

  logic ck_filt;
  logic dt_filt;
  logic ck_filt_d;
  logic step_up;
  logic step_dn;

  logic                          re_d;
  state_t                        state;
  state_t                        state_nxt;
  logic                          snap;

  logic signed [COUNT_WIDTH-1:0] acc;
  logic signed [COUNT_WIDTH-1:0] acc_base;
  logic signed [COUNT_WIDTH-1:0] acc_nxt;
  logic signed [COUNT_WIDTH-1:0] out_q;

  assign pin_raw = {dt, ck};

  // ---------------------------------------------------------------------------
  // Synchroniser and debounce. A level change is accepted only after the
  // synchronised level has disagreed with filt for DEBOUNCE_CYCLES
  // consecutive cycles; a single agreeing cycle restarts the count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (reset) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
      filt  <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= pin_raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          filt[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign ck_filt = filt[0];
  assign dt_filt = filt[1];

  // ---------------------------------------------------------------------------
  // Step decode: only the rising edge of filtered ck counts, so a full
  // detent produces exactly one step. dt at that edge gives the direction.
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (reset) begin
      ck_filt_d <= 1'b1;
    end else begin
      ck_filt_d <= ck_filt;
    end
  end

  assign step_up = ck_filt & ~ck_filt_d & ~dt_filt;
  assign step_dn = ck_filt & ~ck_filt_d &  dt_filt;

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (reset) begin
      state <= IDLE;
      re_d  <= 1'b0;
    end else begin
      state <= state_nxt;
      re_d  <= rd.read_enable;
    end
  end

  always_comb begin
    state_nxt = state;
    snap      = 1'b0;
    case (state)
      IDLE: begin
        if (rd.read_enable && !re_d) begin
          snap      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!rd.read_enable) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Accumulator. On a snapshot the base is cleared before the step is
  // applied, so a step landing on the snapshot edge goes into the new count
  // instead of being lost or counted twice.
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_base = snap ? '0 : acc;
    acc_nxt  = acc_base;
    if (step_up && (acc_base != ACC_MAX)) begin
      acc_nxt = acc_base + ACC_ONE;
    end else if (step_dn && (acc_base != ACC_MIN)) begin
      acc_nxt = acc_base - ACC_ONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      acc   <= '0;
      out_q <= '0;
    end else begin
      acc <= acc_nxt;
      if (snap) begin
        out_q <= acc;
      end
    end
  end

  assign rd.out       = out_q;
  assign rd.out_valid = (state == HOLD);

endmodule

// File: doc/quad_dial_decoder.md
# quad_dial_decoder

Front-end for the front-panel rotary frequency dial. It synchronises and debounces the raw quadrature `ck`/`dt` pins and decodes one signed step per detent. Steps accumulate in a saturating signed counter. On request, a snapshot-and-clear handshake hands the accumulated count to the command dispatcher, which forwards it to the MCU as a frequency-increment delta.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000: consecutive stable `aclk` cycles required before a pin level change is accepted (≥1).
- `COUNT_WIDTH`, default 8: width of the signed accumulator and of `out`.

Ports:
- `aclk` in 1: system clock; everything is in this single clock domain.
- `reset` in 1: synchronous, active-high master reset.
- `ck` in 1: raw dial clock pin, asynchronous, idles high.
- `dt` in 1: raw dial data pin, asynchronous, idles high.
- `read_enable` in 1: read request, level-held by the consumer.
- `out` out COUNT_WIDTH: signed step count captured at the last read.
- `out_valid` out 1: high while `out` holds a snapshot for the current request.

## Operation
- Synchroniser: 2-flop chain per pin; both stages reset to 1.
- Debounce, per pin:
  - `filt` resets to 1.
  - A counter increments each cycle that the synchronised level differs from `filt`.
  - Any cycle where they agree clears the counter to 0.
  - When the counter reaches `DEBOUNCE_CYCLES`, `filt` takes the new level and the counter clears.
- Decode: `ck_filt_d` is a registered copy of `ck_filt`, reset to 1.
  - A rising edge (`ck_filt`=1, `ck_filt_d`=0) produces one step.
  - The step is +1 (clockwise) if `dt_filt`=0 and −1 (counter-clockwise) if `dt_filt`=1.
  - Falling edges of `ck` are ignored: one step per detent.
- Accumulator `acc`, signed COUNT_WIDTH, resets to 0.
  - It saturates: increment at +2^(W−1)−1 holds; decrement at −2^(W−1) holds. There is no wrap.
- Read FSM, states IDLE and HOLD; `re_d` is registered `read_enable`, reset 0.
  - IDLE: when `read_enable`=1 and `re_d`=0 (rising edge), then at that edge:
    - `out` ← `acc`;
    - `acc` ← 0 (or ±1, see below);
    - `out_valid` ← 1;
    - go to HOLD.
  - HOLD: while `read_enable`=1, hold `out` and `out_valid`; steps keep accumulating into `acc`.
  - HOLD: when `read_enable`=0, set `out_valid` ← 0 and go to IDLE. `out` retains its last value.
  - A new snapshot requires `read_enable` to fall and rise again.
- Simultaneous step and snapshot in the same cycle: `out` gets the pre-step `acc`, and `acc` ← the step (±1). No step is lost or double-counted.
- Because `re_d` resets to 0, a `read_enable` held high across reset release counts as a rising edge on the first post-reset cycle.
- Reset mid-operation (any state): on that edge:
  - `out`=0, `out_valid`=0, `acc`=0, FSM=IDLE;
  - synchronisers and `filt` = 1; debounce counters = 0.

## Timing
- Reset values: `out`=0, `out_valid`=0.
- Pin edge to `filt` update: suppose a clean pin change is sampled at edge n. The synchronised level changes at edge n+1, and `filt` updates at edge n+1+`DEBOUNCE_CYCLES`.
- `filt` to `acc`: `acc` reflects the step after edge n+2+`DEBOUNCE_CYCLES`. The step must be decoded on the edge where `ck_filt`=1 and `ck_filt_d`=0.
- Read latency: suppose `read_enable` is first high before edge k. Then `out` and `out_valid` are valid after edge k, i.e. 1-cycle latency.
- Release: `read_enable` low before edge j drops `out_valid` after edge j.
- Glitches: pulses on the synchronised level shorter than `DEBOUNCE_CYCLES` cycles never reach `filt`.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4 and `COUNT_WIDTH`=8.
1. Reset: assert `reset` 3 cycles with pins toggling → `out`=0, `out_valid`=0, and an immediate read returns `out`=0.
2. Three clockwise detents (`dt`=0 at `ck` rise, pins held 10 cycles per phase), then a read → `out`=3 with `out_valid` 1 cycle after `read_enable` rises. Drop and re-raise `read_enable` → `out`=0.
3. Bounce: before a real `ck` rise, inject `ck` glitches of 1–3 cycles → exactly one step, and a read gives `out`=1.
4. Saturation: 130 clockwise detents → `out`=127 (0x7F). Then 130 counter-clockwise detents → `out`=−128 (0x80).
5. Collision: `acc`=5 and a clockwise step's `ck_filt` rise lands on the same edge as the `read_enable` rise → `out`=5, and the next read gives `out`=1.
6. Reset mid-read: in HOLD with `out`=7 and `out_valid`=1, pulse `reset` for 1 cycle → `out`=0, `out_valid`=0, and `acc` reads back 0. `read_enable` still high after reset → snapshot on the first post-reset edge.
